// File: rtl/inert_intf.sv
// Inertial sensor command sequencer: waits out power-up, writes four config
// registers through the SPI monarch, then reads yaw rate on each data-ready INT.
module inert_intf #(
    parameter int TMR_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] yaw_rt,
    output logic        vld
);

    localparam logic [15:0] CFG0 = 16'h0D02;  // enable data-ready INT
    localparam logic [15:0] CFG1 = 16'h1053;  // accel config
    localparam logic [15:0] CFG2 = 16'h1150;  // gyro config
    localparam logic [15:0] CFG3 = 16'h1460;  // rounding
    localparam logic [15:0] RDL  = 16'hA600;  // read yaw low byte
    localparam logic [15:0] RDH  = 16'hA700;  // read yaw high byte

    localparam logic [TMR_W-1:0] TMR_ONE = 1;

    typedef enum logic [2:0] {
        INIT1,
        INIT2,
        INIT3,
        INIT4,
        WAIT_INT,
        RD_L,
        RD_H
    } state_t;

    state_t           state;
    logic             int_ff1;
    logic             int_ff2;
    logic [TMR_W-1:0] tmr;
    logic [7:0]       yaw_l;
    logic             tmr_full;
    logic             done_ok;

    assign tmr_full = &tmr;

    // While wrt is high the monarch has not yet cleared done, so the level
    // seen in that cycle belongs to the previous transaction.
    assign done_ok = done && !wrt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_ff1 <= 1'b0;
            int_ff2 <= 1'b0;
        end else begin
            int_ff1 <= INT;
            int_ff2 <= int_ff1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr <= '0;
        end else if (state == INIT1) begin
            tmr <= tmr + TMR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= INIT1;
            wrt    <= 1'b0;
            cmd    <= '0;
            yaw_rt <= '0;
            vld    <= 1'b0;
            yaw_l  <= '0;
        end else begin
            // Strobes default low so each lasts exactly one cycle.
            wrt <= 1'b0;
            vld <= 1'b0;
            unique case (state)
                INIT1: if (tmr_full) begin
                    wrt   <= 1'b1;
                    cmd   <= CFG0;
                    state <= INIT2;
                end
                INIT2: if (done_ok) begin
                    wrt   <= 1'b1;
                    cmd   <= CFG1;
                    state <= INIT3;
                end
                INIT3: if (done_ok) begin
                    wrt   <= 1'b1;
                    cmd   <= CFG2;
                    state <= INIT4;
                end
                INIT4: if (done_ok) begin
                    wrt   <= 1'b1;
                    cmd   <= CFG3;
                    state <= WAIT_INT;
                end
                WAIT_INT: if (done_ok && int_ff2) begin
                    wrt   <= 1'b1;
                    cmd   <= RDL;
                    state <= RD_L;
                end
                RD_L: if (done_ok) begin
                    yaw_l <= rd_data[7:0];
                    wrt   <= 1'b1;
                    cmd   <= RDH;
                    state <= RD_H;
                end
                RD_H: if (done_ok) begin
                    yaw_rt <= {rd_data[7:0], yaw_l};
                    vld    <= 1'b1;
                    state  <= WAIT_INT;
                end
                default: state <= INIT1;
            endcase
        end
    end

endmodule

// File: tb/tb_inert_intf.sv
// Bench for inert_intf: monarch responder model, command/yaw scoreboards,
// table-driven read vectors plus early-INT, mid-read reset and stale-done runs.
module tb_inert_intf;

    localparam logic [15:0] CFG0 = 16'h0D02;
    localparam logic [15:0] CFG1 = 16'h1053;
    localparam logic [15:0] CFG2 = 16'h1150;
    localparam logic [15:0] CFG3 = 16'h1460;
    localparam logic [15:0] RDL  = 16'hA600;
    localparam logic [15:0] RDH  = 16'hA700;

    typedef struct {
        logic [15:0] rdl_word;
        logic [15:0] rdh_word;
        logic [15:0] exp_yaw;
    } rd_vec_t;

    logic        clk;
    logic        rst_n;
    logic        INT;
    logic        done;
    logic [15:0] rd_data;
    logic        wrt;
    logic [15:0] cmd;
    logic [15:0] yaw_rt;
    logic        vld;

    int          checks;
    int          errors;
    logic [15:0] cmd_q[$];
    logic [15:0] yaw_q[$];
    logic [15:0] prev_yaw;
    rd_vec_t     vecs[4];

    // Responder controls
    int          resp_lat;
    logic        done_rst;
    logic [15:0] lo_word;
    logic [15:0] hi_word;
    int          cnt;
    logic [15:0] pend_cmd;

    inert_intf #(.TMR_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .INT    (INT),
        .done   (done),
        .rd_data(rd_data),
        .wrt    (wrt),
        .cmd    (cmd),
        .yaw_rt (yaw_rt),
        .vld    (vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monarch model: clears done on the edge sampling wrt, raises it with
    // read data resp_lat edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done     <= done_rst;
            cnt      <= 0;
            rd_data  <= '0;
            pend_cmd <= '0;
        end else if (wrt) begin
            done     <= 1'b0;
            cnt      <= resp_lat;
            pend_cmd <= cmd;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                done    <= 1'b1;
                rd_data <= (pend_cmd == RDL) ? lo_word :
                           (pend_cmd == RDH) ? hi_word : 16'h0000;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // One cycle; scoreboards compare whatever the DUT produced this cycle.
    task automatic tick();
        @(negedge clk);
        if (!rst_n) begin
            prev_yaw = yaw_rt;
            return;
        end
        if (wrt) begin
            if (cmd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wrt got=%h expected=none", cmd);
            end else begin
                check("wrt_cmd", {16'h0000, cmd}, {16'h0000, cmd_q.pop_front()});
            end
        end
        if (vld) begin
            if (yaw_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_vld got=%h expected=none", yaw_rt);
            end else begin
                check("yaw_rt", {16'h0000, yaw_rt}, {16'h0000, yaw_q.pop_front()});
            end
        end else if (yaw_rt !== prev_yaw) begin
            checks++;
            errors++;
            $display("FAIL yaw_change_without_vld got=%h expected=%h", yaw_rt, prev_yaw);
        end
        prev_yaw = yaw_rt;
    endtask

    task automatic wait_wrt(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!wrt && n < 200);
        if (!wrt) begin
            checks++;
            errors++;
            $display("FAIL wrt_timeout got=none expected=wrt within 200 cycles");
        end
    endtask

    task automatic wait_vld(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!vld && n < 200);
        if (!vld) begin
            checks++;
            errors++;
            $display("FAIL vld_timeout got=none expected=vld within 200 cycles");
        end
    endtask

    task automatic push_cfg();
        cmd_q.push_back(CFG0);
        cmd_q.push_back(CFG1);
        cmd_q.push_back(CFG2);
        cmd_q.push_back(CFG3);
    endtask

    // Called with rst_n just released on a falling edge.
    task automatic run_config();
        int n;
        wait_wrt(n);
        check("pwrup_to_cfg0", n, 16);
        for (int i = 0; i < 3; i++) begin
            wait_wrt(n);
            check("cfg_gap", n, resp_lat + 2);
        end
    endtask

    task automatic apply_reset(input logic d_rst, input int lat, input logic int_lvl);
        tick();
        done_rst = d_rst;
        resp_lat = lat;
        INT      = int_lvl;
        rst_n    = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int n;
        vecs[0] = '{16'hFF34, 16'h0012, 16'h1234};
        vecs[1] = '{16'h12F0, 16'h34FF, 16'hFFF0};
        vecs[2] = '{16'hAB80, 16'hCD7F, 16'h7F80};
        vecs[3] = '{16'h5501, 16'h6600, 16'h0001};

        checks   = 0;
        errors   = 0;
        prev_yaw = '0;
        done_rst = 1'b0;
        resp_lat = 40;
        lo_word  = '0;
        hi_word  = '0;
        INT      = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        check("rst_wrt", {31'b0, wrt}, 0);
        check("rst_vld", {31'b0, vld}, 0);
        check("rst_cmd", {16'h0000, cmd}, 0);
        check("rst_yaw", {16'h0000, yaw_rt}, 0);

        // Power-up and configuration, then table-driven reads
        push_cfg();
        rst_n = 1'b1;
        run_config();
        repeat (resp_lat + 5) tick();
        for (int i = 0; i < 4; i++) begin
            lo_word = vecs[i].rdl_word;
            hi_word = vecs[i].rdh_word;
            cmd_q.push_back(RDL);
            cmd_q.push_back(RDH);
            yaw_q.push_back(vecs[i].exp_yaw);
            INT = 1'b1;
            wait_wrt(n);
            check("int_to_rdl", n, 3);
            wait_wrt(n);
            check("rdl_to_rdh", n, resp_lat + 2);
            INT = 1'b0;
            wait_vld(n);
            check("rdh_to_vld", n, resp_lat + 2);
            tick();
            check("vld_one_cycle", {31'b0, vld}, 0);
            repeat (4) tick();
            check("yaw_hold", {16'h0000, yaw_rt}, {16'h0000, vecs[i].exp_yaw});
        end

        // Early INT: held high from reset, two back-to-back read pairs
        apply_reset(1'b0, 40, 1'b1);
        lo_word = 16'h0001;
        hi_word = 16'h0080;
        push_cfg();
        for (int i = 0; i < 2; i++) begin
            cmd_q.push_back(RDL);
            cmd_q.push_back(RDH);
            yaw_q.push_back(16'h8001);
        end
        rst_n = 1'b1;
        run_config();
        wait_wrt(n);
        check("cfg3_to_rdl", n, resp_lat + 2);
        wait_wrt(n);
        check("rdl_to_rdh", n, resp_lat + 2);
        wait_wrt(n);
        check("rdh_to_next_rdl", n, resp_lat + 3);
        wait_wrt(n);
        check("rdl_to_rdh", n, resp_lat + 2);
        INT = 1'b0;
        wait_vld(n);
        check("rdh_to_vld", n, resp_lat + 2);
        repeat (resp_lat + 10) tick();
        check("early_cmd_q_empty", cmd_q.size(), 0);
        check("early_yaw_q_empty", yaw_q.size(), 0);

        // Mid-read reset: reset lands while RDH is outstanding
        lo_word = 16'h1111;
        hi_word = 16'h2222;
        cmd_q.push_back(RDL);
        cmd_q.push_back(RDH);
        INT = 1'b1;
        wait_wrt(n);
        check("int_to_rdl", n, 3);
        wait_wrt(n);
        INT = 1'b0;
        repeat (10) tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_wrt", {31'b0, wrt}, 0);
        check("async_rst_vld", {31'b0, vld}, 0);
        check("async_rst_cmd", {16'h0000, cmd}, 0);
        check("async_rst_yaw", {16'h0000, yaw_rt}, 0);
        tick();
        tick();
        tick();
        push_cfg();
        rst_n = 1'b1;
        run_config();
        repeat (resp_lat + 5) tick();
        check("midrst_yaw_q_empty", yaw_q.size(), 0);
        check("midrst_cmd_q_empty", cmd_q.size(), 0);

        // Stale done: done high out of reset and low for only one cycle per wrt
        apply_reset(1'b1, 1, 1'b1);
        lo_word = 16'h005A;
        hi_word = 16'h005A;
        push_cfg();
        cmd_q.push_back(RDL);
        cmd_q.push_back(RDH);
        yaw_q.push_back(16'h5A5A);
        rst_n = 1'b1;
        run_config();
        wait_wrt(n);
        check("stale_cfg3_to_rdl", n, resp_lat + 2);
        wait_wrt(n);
        check("stale_rdl_to_rdh", n, resp_lat + 2);
        INT = 1'b0;
        wait_vld(n);
        check("stale_rdh_to_vld", n, resp_lat + 2);
        repeat (20) tick();
        check("stale_cmd_q_empty", cmd_q.size(), 0);
        check("stale_yaw_q_empty", yaw_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
